// File: rtl/tiny_fft_n_pkg.sv
// Shared types and helpers for the N-point tiny FFT: state enum, twiddle ROM, bit reversal, saturation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tiny_fft_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   // One full turn in 16 steps, scaled by 127 (Q1.7, +1.0 is not representable).
   // Entry k holds round(127*cos(2*pi*k/16)) and round(127*sin(2*pi*k/16)).
   localparam logic signed [7:0] COS_ROM [16] = '{
       8'sd127,  8'sd117,  8'sd90,   8'sd49,   8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
      -8'sd127, -8'sd117, -8'sd90,  -8'sd49,   8'sd0,    8'sd49,   8'sd90,   8'sd117
   };
   localparam logic signed [7:0] SIN_ROM [16] = '{
       8'sd0,    8'sd49,   8'sd90,   8'sd117,  8'sd127,  8'sd117,  8'sd90,   8'sd49,
       8'sd0,   -8'sd49,  -8'sd90,  -8'sd117, -8'sd127, -8'sd117, -8'sd90,  -8'sd49
   };

   // Reverse the low 'bits' bits of v (bits = 2, 3 or 4); upper bits return 0.
   function automatic logic [3:0] bitrev(input logic [3:0] v, input int bits);
      logic [3:0] r;
      case (bits)
         2:       r = {2'b00, v[0], v[1]};
         3:       r = {1'b0, v[0], v[1], v[2]};
         default: r = {v[0], v[1], v[2], v[3]};
      endcase
      return r;
   endfunction

   // Clamp a signed value into the w-bit two's complement range.
   function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/tiny_fft_n_butterfly.sv
// Radix-2 DIT butterfly: A' = sat(A + B*W), B' = sat(A - B*W), W = cos - j*sin.
// Latency: combinational.
// Backpressure: none.
// Ports: a_*/b_* complex inputs (OUT_W), w_re/w_im twiddle (TW_W, Q1.(TW_W-1)),
//        w_unity selects W = 1 exactly, ap_*/bp_* saturated results (OUT_W).
module fft_butterfly
   import tiny_fft_pkg::*;
#(
   parameter int OUT_W = 7,
   parameter int TW_W  = 8
) (
   input  logic signed [OUT_W-1:0] a_re,
   input  logic signed [OUT_W-1:0] a_im,
   input  logic signed [OUT_W-1:0] b_re,
   input  logic signed [OUT_W-1:0] b_im,
   input  logic signed [TW_W-1:0]  w_re,
   input  logic signed [TW_W-1:0]  w_im,
   input  logic                    w_unity,
   output logic signed [OUT_W-1:0] ap_re,
   output logic signed [OUT_W-1:0] ap_im,
   output logic signed [OUT_W-1:0] bp_re,
   output logic signed [OUT_W-1:0] bp_im
);

   // Headroom for the full complex product plus the final add/sub.
   localparam int PW = OUT_W + TW_W + 2;

   logic signed [PW-1:0] prod_re;
   logic signed [PW-1:0] prod_im;
   logic signed [PW-1:0] t_re;
   logic signed [PW-1:0] t_im;

   always_comb begin
      prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
      prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
      // k = 0 twiddle is exactly 1: skip the multiply so no truncation error creeps in.
      if (w_unity) begin
         t_re = PW'(b_re);
         t_im = PW'(b_im);
      end else begin
         // Arithmetic shift floors toward -inf.
         t_re = prod_re >>> (TW_W - 1);
         t_im = prod_im >>> (TW_W - 1);
      end
      ap_re = OUT_W'(sat(32'(PW'(a_re) + t_re), OUT_W));
      ap_im = OUT_W'(sat(32'(PW'(a_im) + t_im), OUT_W));
      bp_re = OUT_W'(sat(32'(PW'(a_re) - t_re), OUT_W));
      bp_im = OUT_W'(sat(32'(PW'(a_im) - t_im), OUT_W));
   end

endmodule

// File: rtl/tiny_fft_n.sv
// N-point radix-2 DIT FFT: serial load, in-place compute (one butterfly/cycle), serial bin readout.
// Latency: log2(N)*N/2 compute cycles after the N-th sample; first bin word the cycle after.
// Backpressure: none; output streams continuously, wr_en during OUTPUT restarts a load.
// Ports: clk, rst (sync, active-high), wr_en/data_in sample input (IN_W signed),
//        data_out (OUT_W signed), real_num, rd_idx_zero, busy.
// Option TINY_FFT_MAG_EN: adds a third magnitude word per bin and the mag_num port.
module tiny_fft_n
   import tiny_fft_pkg::*;
#(
   parameter int POINTS = 8,
   parameter int IN_W   = 4,
   parameter int OUT_W  = IN_W + $clog2(POINTS),
   parameter int TW_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic signed [IN_W-1:0]  data_in,
   output logic signed [OUT_W-1:0] data_out,
   output logic                    real_num,
   output logic                    rd_idx_zero,
   output logic                    busy
`ifdef TINY_FFT_MAG_EN
   ,
   output logic                    mag_num
`endif
);

   localparam int LG   = $clog2(POINTS);
   localparam int HALF = POINTS / 2;
`ifdef TINY_FFT_MAG_EN
   localparam int WPB  = 3;   // words per bin: re, im, magnitude
`else
   localparam int WPB  = 2;   // words per bin: re, im
`endif

   if (!(POINTS == 4 || POINTS == 8 || POINTS == 16)) begin : g_bad_points
      $error("tiny_fft_n: POINTS must be 4, 8 or 16");
   end
   if (TW_W != 8) begin : g_bad_tw
      $error("tiny_fft_n: twiddle ROM is 8 bits wide, TW_W must be 8");
   end
   if (OUT_W + TW_W + 2 > 32) begin : g_bad_width
      $error("tiny_fft_n: OUT_W too wide for the saturation helper");
   end

   state_t state;
   state_t next_state;

   logic [LG-1:0]  cnt;
   logic [2:0]     stage;
   logic [LG-2:0]  bfly;
   logic           last_bfly;
   logic           last_stage;

   logic signed [OUT_W-1:0] mem_re [POINTS];
   logic signed [OUT_W-1:0] mem_im [POINTS];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_LOAD:    if (wr_en && cnt == LG'(POINTS - 1)) next_state = ST_COMPUTE;
         ST_COMPUTE: if (last_bfly && last_stage)         next_state = ST_OUTPUT;
         ST_OUTPUT:  if (wr_en)                           next_state = ST_LOAD;
         default:                                         next_state = ST_LOAD;
      endcase
   end

   assign busy = (state == ST_COMPUTE);

   // ---------------------------------------------------------------- load path
   // A write during OUTPUT is sample 0 of a new frame, whatever cnt holds.
   logic           load_wr;
   logic [LG-1:0]  smp_idx;
   logic [LG-1:0]  wr_addr;

   always_comb begin
      load_wr = wr_en && (state == ST_LOAD || state == ST_OUTPUT);
      smp_idx = (state == ST_OUTPUT) ? '0 : cnt;
      wr_addr = LG'(bitrev(4'(smp_idx), LG));
   end

   // ---------------------------------------------------------------- butterfly addressing
   // Stage s pairs elements 2^s apart; pos is the offset inside a group and sets the twiddle.
   // Table index k*16/POINTS reduces to pos << (3 - s) for every legal POINTS.
   logic [LG-1:0]  j_ext;
   logic [LG-1:0]  mask;
   logic [LG-1:0]  pos;
   logic [LG-1:0]  ia;
   logic [LG-1:0]  ib;
   logic [3:0]     tw_idx;

   always_comb begin
      j_ext      = LG'(bfly);
      mask       = (LG'(1) << stage) - LG'(1);
      pos        = j_ext & mask;
      ia         = ((j_ext & ~mask) << 1) | pos;
      ib         = ia | (LG'(1) << stage);
      tw_idx     = 4'(pos) << (3'd3 - stage);
      last_bfly  = (bfly == (LG-1)'(HALF - 1));
      last_stage = (stage == 3'(LG - 1));
   end

   logic signed [TW_W-1:0]  w_re;
   logic signed [TW_W-1:0]  w_im;
   logic signed [OUT_W-1:0] bf_ap_re;
   logic signed [OUT_W-1:0] bf_ap_im;
   logic signed [OUT_W-1:0] bf_bp_re;
   logic signed [OUT_W-1:0] bf_bp_im;

   assign w_re = TW_W'(COS_ROM[tw_idx]);
   assign w_im = TW_W'(-SIN_ROM[tw_idx]);

   fft_butterfly #(
      .OUT_W (OUT_W),
      .TW_W  (TW_W)
   ) u_bfly (
      .a_re    (mem_re[ia]),
      .a_im    (mem_im[ia]),
      .b_re    (mem_re[ib]),
      .b_im    (mem_im[ib]),
      .w_re    (w_re),
      .w_im    (w_im),
      .w_unity (pos == '0),
      .ap_re   (bf_ap_re),
      .ap_im   (bf_ap_im),
      .bp_re   (bf_bp_re),
      .bp_im   (bf_bp_im)
   );

   // ---------------------------------------------------------------- storage (not cleared by reset)
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (load_wr) begin
            mem_re[wr_addr] <= OUT_W'(data_in);
            mem_im[wr_addr] <= '0;
         end else if (state == ST_COMPUTE) begin
            mem_re[ia] <= bf_ap_re;
            mem_im[ia] <= bf_ap_im;
            mem_re[ib] <= bf_bp_re;
            mem_im[ib] <= bf_bp_im;
         end
      end
   end

   // ---------------------------------------------------------------- counters
   // cnt wraps to 0 on the last sample; stage/bfly return to 0 after the last butterfly,
   // so each new COMPUTE starts from the first pair without an explicit clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         stage <= '0;
         bfly  <= '0;
      end else begin
         if (load_wr) cnt <= smp_idx + LG'(1);
         if (state == ST_COMPUTE) begin
            if (last_bfly) begin
               bfly  <= '0;
               stage <= last_stage ? 3'd0 : stage + 3'd1;
            end else begin
               bfly  <= bfly + (LG-1)'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------- output stream
   // The register is loaded on the edge that enters or stays in OUTPUT, so data_out is
   // non-zero only while state is OUTPUT. On entry from COMPUTE, bin 0 is already final:
   // the last butterfly of the last stage never touches element 0.
   logic [LG-1:0]  bin;
   logic [1:0]     wsel;
   logic [LG-1:0]  nx_bin;
   logic [1:0]     nx_wsel;
   logic signed [OUT_W-1:0] nx_word;
   logic signed [OUT_W-1:0] rd_re;
   logic signed [OUT_W-1:0] rd_im;

   always_comb begin
      nx_bin  = '0;
      nx_wsel = '0;
      if (state == ST_OUTPUT) begin
         if (wsel == 2'(WPB - 1)) begin
            nx_bin  = bin + LG'(1);
            nx_wsel = '0;
         end else begin
            nx_bin  = bin;
            nx_wsel = wsel + 2'd1;
         end
      end
      rd_re = mem_re[nx_bin];
      rd_im = mem_im[nx_bin];
   end

`ifdef TINY_FFT_MAG_EN
   // |X| ~= max + min/2 on absolute values; one extra bit holds |most negative|.
   logic signed [OUT_W:0]   abs_re;
   logic signed [OUT_W:0]   abs_im;
   logic signed [OUT_W:0]   mag_mx;
   logic signed [OUT_W:0]   mag_mn;
   logic signed [OUT_W+1:0] mag_sum;
   logic signed [OUT_W-1:0] mag_word;

   always_comb begin
      abs_re   = (rd_re < 0) ? -(OUT_W+1)'(rd_re) : (OUT_W+1)'(rd_re);
      abs_im   = (rd_im < 0) ? -(OUT_W+1)'(rd_im) : (OUT_W+1)'(rd_im);
      mag_mx   = (abs_re > abs_im) ? abs_re : abs_im;
      mag_mn   = (abs_re > abs_im) ? abs_im : abs_re;
      mag_sum  = (OUT_W+2)'(mag_mx) + (OUT_W+2)'(mag_mn >>> 1);
      mag_word = OUT_W'(sat(32'(mag_sum), OUT_W));
   end
`endif

   always_comb begin
      case (nx_wsel)
         2'd0:    nx_word = rd_re;
         2'd1:    nx_word = rd_im;
`ifdef TINY_FFT_MAG_EN
         default: nx_word = mag_word;
`else
         default: nx_word = '0;
`endif
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || next_state != ST_OUTPUT) begin
         bin         <= '0;
         wsel        <= '0;
         data_out    <= '0;
         real_num    <= 1'b0;
         rd_idx_zero <= 1'b0;
`ifdef TINY_FFT_MAG_EN
         mag_num     <= 1'b0;
`endif
      end else begin
         bin         <= nx_bin;
         wsel        <= nx_wsel;
         data_out    <= nx_word;
         real_num    <= (nx_wsel == 2'd0);
         rd_idx_zero <= (nx_bin == '0);
`ifdef TINY_FFT_MAG_EN
         mag_num     <= (nx_wsel == 2'd2);
`endif
      end
   end

endmodule
